// File: rtl/bomberman_pkg.sv
// Shared playfield geometry and the bomb-slot state encoding.
package bomberman_pkg;

  localparam logic [9:0] MIN_X       = 10'd143;
  localparam logic [9:0] MIN_Y       = 10'd34;
  localparam logic [9:0] TILE        = 10'd16;
  localparam logic [9:0] BLAST_REACH = 10'd48;

  typedef enum logic [1:0] {
    SLOT_IDLE      = 2'd0,
    SLOT_ARMED     = 2'd1,
    SLOT_PENDING   = 2'd2,
    SLOT_EXPLODING = 2'd3
  } slot_state_e;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: lifecycle FSM, shared fuse/explosion down-counter and tile coordinates.
module bomb_slot
  import bomberman_pkg::*;
#(
  parameter int FUSE_CYCLES = 200_000_000,
  parameter int EXP_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc,
  input  logic [9:0]  tile_x,
  input  logic [9:0]  tile_y,
  input  logic        grant,
  input  logic        chain_hit,
  output slot_state_e state,
  output logic [9:0]  x,
  output logic [9:0]  y
);

  localparam int CNT_MAX = (FUSE_CYCLES > EXP_CYCLES) ? FUSE_CYCLES : EXP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SLOT_IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      unique case (state)
        SLOT_IDLE: begin
          if (alloc) begin
            state <= SLOT_ARMED;
            cnt   <= FUSE_LAST;
            x     <= tile_x;
            y     <= tile_y;
          end
        end
        SLOT_ARMED: begin
          if (cnt == '0 || chain_hit) state <= SLOT_PENDING;
          else                        cnt   <= cnt - 1'b1;
        end
        SLOT_PENDING: begin
          if (grant) begin
            state <= SLOT_EXPLODING;
            cnt   <= EXP_LAST;
          end
        end
        SLOT_EXPLODING: begin
          if (cnt == '0) begin
            state <= SLOT_IDLE;
            x     <= '0;
            y     <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bomb_controller.sv
// Bomb placement, per-slot fuses and the shared explosion port.
// Optional BOMB_CHAIN_EN: a blast pushes armed bombs on its cross straight to detonation.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int MAX_BOMBS   = 2,
  parameter int FUSE_CYCLES = 200_000_000,
  parameter int EXP_CYCLES  = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C,
  input  logic [9:0]             b_x,
  input  logic [9:0]             b_y,
  input  logic                   game_over,
  output logic                   explosion_SCEN,
  output logic [9:0]             e_x,
  output logic [9:0]             e_y,
  output logic [MAX_BOMBS-1:0]   bomb_armed,
  output logic [MAX_BOMBS-1:0]   bomb_exploding,
  output logic [20*MAX_BOMBS-1:0] bomb_xy
);

  // Snap the sprite centre onto the tile grid (10-bit wrap-around arithmetic).
  function automatic logic [9:0] snap(input logic [9:0] pos, input logic [9:0] origin);
    logic [9:0] rel;
    rel = pos + (TILE >> 1) - origin;
    return origin + (rel & ~(TILE - 10'd1));
  endfunction

`ifdef BOMB_CHAIN_EN
  function automatic logic within_reach(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return diff <= BLAST_REACH;
  endfunction
`endif

  logic        c_q;
  logic        press_vld_p0;
  logic [9:0]  tile_x_p0, tile_y_p0;
  logic        det_vld_p1;
  logic [9:0]  det_x_p1, det_y_p1;

  slot_state_e          slot_state [MAX_BOMBS];
  logic [9:0]           slot_x [MAX_BOMBS];
  logic [9:0]           slot_y [MAX_BOMBS];
  logic [MAX_BOMBS-1:0] idle, pending, dup, alloc, grant, chain_hit;
  logic [9:0]           win_x, win_y;
  logic                 taken, won;

  // Stage p0: edge-detect the button and snap the requested tile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q          <= 1'b0;
      press_vld_p0 <= 1'b0;
      tile_x_p0    <= '0;
      tile_y_p0    <= '0;
    end else begin
      c_q          <= C;
      press_vld_p0 <= C && !c_q && !game_over;
      tile_x_p0    <= snap(b_x, MIN_X);
      tile_y_p0    <= snap(b_y, MIN_Y);
    end
  end

  for (genvar k = 0; k < MAX_BOMBS; k++) begin : g_slot
    assign idle[k]    = (slot_state[k] == SLOT_IDLE);
    assign pending[k] = (slot_state[k] == SLOT_PENDING);
    assign dup[k]     = !idle[k] && (slot_x[k] == tile_x_p0) && (slot_y[k] == tile_y_p0);

    assign bomb_armed[k]     = (slot_state[k] == SLOT_ARMED) || pending[k];
    assign bomb_exploding[k] = (slot_state[k] == SLOT_EXPLODING);
    assign bomb_xy[20*k +: 20] = {slot_x[k], slot_y[k]};

`ifdef BOMB_CHAIN_EN
    assign chain_hit[k] = explosion_SCEN &&
                          (((slot_y[k] == e_y) && within_reach(slot_x[k], e_x)) ||
                           ((slot_x[k] == e_x) && within_reach(slot_y[k], e_y)));
`else
    assign chain_hit[k] = 1'b0;
`endif

    bomb_slot #(
      .FUSE_CYCLES (FUSE_CYCLES),
      .EXP_CYCLES  (EXP_CYCLES)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .alloc     (alloc[k]),
      .tile_x    (tile_x_p0),
      .tile_y    (tile_y_p0),
      .grant     (grant[k]),
      .chain_hit (chain_hit[k]),
      .state     (slot_state[k]),
      .x         (slot_x[k]),
      .y         (slot_y[k])
    );
  end

  // Lowest-index IDLE slot takes the press; lowest-index PENDING slot takes the port.
  always_comb begin
    alloc = '0;
    grant = '0;
    taken = 1'b0;
    won   = 1'b0;
    win_x = '0;
    win_y = '0;
    for (int k = 0; k < MAX_BOMBS; k++) begin
      if (idle[k] && !taken) begin
        alloc[k] = press_vld_p0 && (dup == '0);
        taken    = 1'b1;
      end
      if (pending[k] && !won) begin
        grant[k] = 1'b1;
        win_x    = slot_x[k];
        win_y    = slot_y[k];
        won      = 1'b1;
      end
    end
  end

  // Stage p1: latch the arbitration winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_vld_p1 <= 1'b0;
      det_x_p1   <= '0;
      det_y_p1   <= '0;
    end else begin
      det_vld_p1 <= won;
      det_x_p1   <= win_x;
      det_y_p1   <= win_y;
    end
  end

  // Stage p2: explosion port, coordinates held between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      explosion_SCEN <= 1'b0;
      e_x            <= '0;
      e_y            <= '0;
    end else begin
      explosion_SCEN <= det_vld_p1;
      if (det_vld_p1) begin
        e_x <= det_x_p1;
        e_y <= det_y_p1;
      end
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Scoreboarded bench for bomb_controller with short fuse/explosion timers.
`timescale 1ns/1ps
module tb_bomb_controller;
`ifdef BOMB_CHAIN_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int F = 20;
  localparam int E = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              C;
  logic [9:0]        b_x, b_y;
  logic              game_over;
  logic              explosion_SCEN;
  logic [9:0]        e_x, e_y;
  logic [NB-1:0]     bomb_armed, bomb_exploding;
  logic [20*NB-1:0]  bomb_xy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         at;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  bomb_controller #(
    .MAX_BOMBS   (NB),
    .FUSE_CYCLES (F),
    .EXP_CYCLES  (E)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .C              (C),
    .b_x            (b_x),
    .b_y            (b_y),
    .game_over      (game_over),
    .explosion_SCEN (explosion_SCEN),
    .e_x            (e_x),
    .e_y            (e_y),
    .bomb_armed     (bomb_armed),
    .bomb_exploding (bomb_exploding),
    .bomb_xy        (bomb_xy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Every pulse must match the oldest outstanding expectation (tile and cycle).
  initial forever begin
    @(negedge clk);
    if (explosion_SCEN === 1'b1) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d e=(%0d,%0d) required no pulse", cyc, e_x, e_y);
      end else begin
        got = sb.pop_front();
        if (e_x !== got.x || e_y !== got.y || cyc != got.at) begin
          failures++;
          $display("FAIL pulse got=(%0d,%0d)@%0d required=(%0d,%0d)@%0d",
                   e_x, e_y, cyc, got.x, got.y, got.at);
        end
      end
    end
  end

  task automatic press(input logic [9:0] px, input logic [9:0] py, input bit accept,
                       input logic [9:0] tx, input logic [9:0] ty, output int c0);
    @(negedge clk);
    c0  = cyc;
    b_x = px;
    b_y = py;
    C   = 1'b1;
    if (accept) sb.push_back('{tx, ty, c0 + F + 4});
    @(negedge clk);
    C = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((bomb_armed !== '0 || bomb_exploding !== '0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0; C = 1'b1; game_over = 1'b0; b_x = 10'd143; b_y = 10'd34;
    repeat (3) @(negedge clk);
    checks++;
    if ({explosion_SCEN, e_x, e_y} !== 21'd0) begin
      failures++;
      $display("FAIL reset_port got=%0d/%0d/%0d required 0/0/0", explosion_SCEN, e_x, e_y);
    end
    checks++;
    if (bomb_armed !== '0 || bomb_exploding !== '0 || bomb_xy !== '0) begin
      failures++;
      $display("FAIL reset_slots armed=%b expl=%b xy=%h required all 0", bomb_armed, bomb_exploding, bomb_xy);
    end
    // C still high as reset lifts: counts as a press on the first clock
    reset = 1'b1;
    sb.push_back('{10'd143, 10'd34, cyc + F + 4});
    @(negedge clk);
    C = 1'b0;
    @(negedge clk);
    checks++;
    if (bomb_armed !== NB'(1) || bomb_xy[19:0] !== {10'd143, 10'd34}) begin
      failures++;
      $display("FAIL reset_release_press armed=%b xy0=%h required armed=1 xy0=%h",
               bomb_armed, bomb_xy[19:0], {10'd143, 10'd34});
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL reset_release_drain ok=%0d pending=%0d required 1/0", ok, sb.size());
    end
  endtask

  task automatic test_single();
    bit ok;
    int c0;
    int n_arm = 0;
    int n_exp = 0;
    press(10'd143, 10'd34, 1'b1, 10'd143, 10'd34, c0);
    @(negedge clk);
    checks++;
    if (bomb_armed !== NB'(1) || bomb_xy[19:0] !== {10'd143, 10'd34}) begin
      failures++;
      $display("FAIL single_armed armed=%b xy0=%h required 1/%h", bomb_armed, bomb_xy[19:0], {10'd143, 10'd34});
    end
    while (bomb_armed[0] === 1'b1 && n_arm < 100) begin
      n_arm++;
      @(negedge clk);
    end
    checks++;
    if (n_arm != F + 1) begin
      failures++;
      $display("FAIL single_armed_len got=%0d required=%0d", n_arm, F + 1);
    end
    while (bomb_exploding[0] === 1'b1 && n_exp < 100) begin
      n_exp++;
      @(negedge clk);
    end
    checks++;
    if (n_exp != E) begin
      failures++;
      $display("FAIL single_exploding_len got=%0d required=%0d", n_exp, E);
    end
    checks++;
    if (bomb_xy !== '0 || bomb_armed !== '0) begin
      failures++;
      $display("FAIL single_idle xy=%h armed=%b required 0/0", bomb_xy, bomb_armed);
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0 || e_x !== 10'd143 || e_y !== 10'd34) begin
      failures++;
      $display("FAIL single_hold ok=%0d pending=%0d e=(%0d,%0d) required 1/0/(143,34)", ok, sb.size(), e_x, e_y);
    end
  endtask

  task automatic test_snap();
    bit ok;
    int c0;
    press(10'd200, 10'd60, 1'b1, 10'd207, 10'd66, c0);
    @(negedge clk);
    checks++;
    if (bomb_xy[19:0] !== {10'd207, 10'd66}) begin
      failures++;
      $display("FAIL snap_xy got=(%0d,%0d) required=(207,66)", bomb_xy[19:10], bomb_xy[9:0]);
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0 || e_x !== 10'd207 || e_y !== 10'd66) begin
      failures++;
      $display("FAIL snap_pulse ok=%0d pending=%0d e=(%0d,%0d) required 1/0/(207,66)", ok, sb.size(), e_x, e_y);
    end
  endtask

  task automatic test_capacity();
    bit ok;
    int c0;
    logic [9:0] tx, ty;
    for (int i = 0; i <= NB; i++) begin
      tx = 10'(143 + 64 * i);
      ty = 10'(34 + 64 * i);
      press(tx, ty, i < NB, tx, ty, c0);
    end
    @(negedge clk);
    checks++;
    if (bomb_armed !== '1) begin
      failures++;
      $display("FAIL capacity_armed got=%b required all ones", bomb_armed);
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (bomb_xy[20*k +: 20] !== {10'(143 + 64 * k), 10'(34 + 64 * k)}) begin
        failures++;
        $display("FAIL capacity_xy slot=%0d got=%h required=%h", k, bomb_xy[20*k +: 20],
                 {10'(143 + 64 * k), 10'(34 + 64 * k)});
      end
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL capacity_drain ok=%0d pending=%0d required 1/0", ok, sb.size());
    end
    press(10'd143, 10'd34, 1'b1, 10'd143, 10'd34, c0);
    press(10'd145, 10'd36, 1'b0, 10'd143, 10'd34, c0);
    @(negedge clk);
    checks++;
    if (bomb_armed !== NB'(1)) begin
      failures++;
      $display("FAIL duplicate_tile armed=%b required=%b", bomb_armed, NB'(1));
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL duplicate_drain ok=%0d pending=%0d required 1/0", ok, sb.size());
    end
  endtask

  task automatic test_game_over();
    bit ok;
    int c0;
    press(10'd143, 10'd34, 1'b1, 10'd143, 10'd34, c0);
    game_over = 1'b1;
    press(10'd303, 10'd194, 1'b0, 10'd303, 10'd194, c0);
    @(negedge clk);
    checks++;
    if (bomb_armed !== NB'(1) || bomb_xy[20*NB-1:20] !== '0) begin
      failures++;
      $display("FAIL game_over_block armed=%b xy=%h required armed=%b upper xy 0", bomb_armed, bomb_xy, NB'(1));
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL game_over_fuse ok=%0d pending=%0d required 1/0", ok, sb.size());
    end
    game_over = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0;
    int p0;
    press(10'd143, 10'd34, 1'b0, 10'd143, 10'd34, c0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({explosion_SCEN, e_x, e_y} !== 21'd0 || bomb_armed !== '0 || bomb_exploding !== '0 || bomb_xy !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs scen=%0d e=(%0d,%0d) armed=%b xy=%h required all 0",
               explosion_SCEN, e_x, e_y, bomb_armed, bomb_xy);
    end
    @(negedge clk);
    reset = 1'b1;
    p0 = pulses;
    repeat (40) @(negedge clk);
    checks++;
    if (pulses != p0 || bomb_armed !== '0) begin
      failures++;
      $display("FAIL reset_mid_abort pulses=%0d armed=%b required 0 pulses, armed 0", pulses - p0, bomb_armed);
    end
  endtask

`ifdef BOMB_CHAIN_EN
  task automatic test_chain();
    bit ok;
    int c0;
    int c1;
    int p;
    press(10'd143, 10'd34, 1'b1, 10'd143, 10'd34, c0);
    p = c0 + F + 4;
    repeat (8) @(negedge clk);
    press(10'd159, 10'd34, 1'b0, 10'd159, 10'd34, c1);
    sb.push_back('{10'd159, 10'd34, p + 3});
    press(10'd143, 10'd50, 1'b0, 10'd143, 10'd50, c1);
    sb.push_back('{10'd143, 10'd50, p + 4});
    @(negedge clk);
    checks++;
    if (bomb_armed !== '1) begin
      failures++;
      $display("FAIL chain_armed got=%b required all ones", bomb_armed);
    end
    drain(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++;
      $display("FAIL chain_drain ok=%0d pending=%0d required 1/0", ok, sb.size());
    end
  endtask
`endif

  initial begin
    reset = 1'b0; C = 1'b0; game_over = 1'b0; b_x = '0; b_y = '0;
    test_reset();
    test_single();
    test_snap();
    test_capacity();
    test_game_over();
    test_reset_mid();
`ifdef BOMB_CHAIN_EN
    test_chain();
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses outstanding=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Owns every bomb in play. It turns the player's place-bomb button into tile-aligned bomb slots and runs each slot's fuse. When several fuses expire together it arbitrates the single shared explosion port, issuing one `explosion_SCEN` pulse per cycle with `e_x`/`e_y`, which the player and collision logic consume. It also exports per-slot bomb and blast state to the renderer.

## Interface
- `MAX_BOMBS`, 2: number of bomb slots, 1–8.
- `FUSE_CYCLES`, 200_000_000: clock cycles a bomb stays armed.
- `EXP_CYCLES`, 50_000_000: clock cycles a slot stays in the exploding state.
- `clk`  in  1: system clock; one clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `C`  in  1: place-bomb button, level.
- `b_x`, `b_y`  in  10: bomberman sprite top-left pixel.
- `game_over`  in  1: high blocks new placements.
- `explosion_SCEN`  out  1: single-cycle detonation pulse.
- `e_x`, `e_y`  out  10: tile of the latest detonation, held until the next pulse.
- `bomb_armed`  out  MAX_BOMBS: slot k is in ARMED or PENDING.
- `bomb_exploding`  out  MAX_BOMBS: slot k is in EXPLODING.
- `bomb_xy`  out  20*MAX_BOMBS: slot k holds `{x,y}` in bits [20k+19:20k], x in the upper 10 bits.

## Operation
- Slot states: IDLE → ARMED → PENDING → EXPLODING → IDLE.
- Press detect: register `C` into `c_q`. A press is `C && !c_q`.
- Placement accepted only if all of these hold:
  - `game_over` is 0;
  - at least one slot is IDLE;
  - no non-IDLE slot already holds the same snapped tile.
- A rejected press is dropped, not queued.
- Allocation goes to the lowest-index IDLE slot.
- Tile snap: x = 143 + ((b_x + 8 − 143) & ~15); y = 34 + ((b_y + 8 − 34) & ~15).
  - Arithmetic is 10-bit unsigned; snapping uses the sprite centre.
- ARMED: the fuse counter loads FUSE_CYCLES−1 and decrements. When it reaches 0 the slot moves to PENDING.
- Arbiter: the lowest-index PENDING slot wins. That slot moves to EXPLODING, the pulse fires, and `e_x`/`e_y` take its tile.
- A losing PENDING slot waits; each slot produces exactly one pulse.
- EXPLODING: lasts EXP_CYCLES cycles, then the slot returns to IDLE with its coordinates cleared to 0.
- `game_over` does not stop fuses. Armed bombs still detonate.

## Timing
- Reset (`reset` = 0): all slots IDLE, counters 0, `c_q` = 0. All outputs are 0: `explosion_SCEN`, `e_x`, `e_y`, `bomb_armed`, `bomb_exploding`, `bomb_xy`.
- Reset mid-operation: all fuses abort and no pulse follows.
- `C` held high through reset release counts as a press on the first clock.
- Press sampled at edge n: `bomb_armed[k]` and `bomb_xy` are valid after edge n+1.
- ARMED lasts exactly FUSE_CYCLES cycles. PENDING is visible for at least 1 cycle.
- Arbitration: a PENDING slot granted at edge m has the pulse and `e_x`/`e_y` registered after edge m+1.
- Spacing: simultaneous PENDING slots produce pulses on consecutive cycles, in index order.
- Same-cycle press and expiry: a slot leaving EXPLODING→IDLE at an edge is not allocatable until the following cycle.

## Configuration
- `BOMB_CHAIN_EN` defined: in any cycle where `explosion_SCEN` = 1, every ARMED slot whose tile lies on the blast cross moves to PENDING at the next edge. Blast cross means:
  - same y and |dx| ≤ 48, or
  - same x and |dy| ≤ 48.
- `BOMB_CHAIN_EN` undefined: blasts never affect other slots; each bomb runs its full fuse.

## Structure
- Package `bomberman_pkg` holds:
  - MIN_X = 143, MIN_Y = 34;
  - TILE = 16;
  - BLAST_REACH = 48;
  - the slot-state enum.
- Sub-module `bomb_slot` holds one slot's FSM, fuse/explosion counter and coordinates. Instantiate it MAX_BOMBS times with a generate loop.
- Top level holds press detect, tile snap, duplicate check, allocation, priority arbiter and output registers.

## Test plan
All scenarios use FUSE_CYCLES = 20 and EXP_CYCLES = 5.
1. b = (143, 34), one C press → slot 0 armed with xy (143, 34) → ARMED 20 cycles → one pulse with e = (143, 34) → `bomb_exploding[0]` high for 5 cycles → IDLE.
2. b = (200, 60), press → snapped tile is (207, 66).
3. MAX_BOMBS = 2:
   - three presses on distinct tiles → only two bombs armed;
   - two presses on the same tile → only one armed.
4. `game_over` = 1, press → no slot allocated. A bomb armed earlier still pulses on schedule.
5. `reset` pulled low 10 cycles into a fuse → all outputs 0; no `explosion_SCEN` for 40 cycles afterwards.
6. `BOMB_CHAIN_EN`, MAX_BOMBS = 3, bombs at (143, 34), (159, 34) and (143, 50) → after slot 0's pulse, slots 1 and 2 pulse on consecutive cycles in index order.
